fifo_native_rr_read_scheduler: RTL
==================================

# fifo_native_rr_read_scheduler

Round-robin read scheduler that shares one downstream AXIS skid/output buffer among NUM_CH native-interface FIFOs. It grants one channel at a time for bursts of up to BURST_LEN reads and drives that channel's read enable. A credit counter guarantees the shared buffer never overflows. It also emits a channel tag aligned with read data so the datapath can stamp TDEST/TID.

## Interface
- NUM_CH, 4: number of native FIFOs arbitrated (2..16)
- DOUT_PIPE_NUMBER, 1: cycles from fifo_rden to FIFO data valid (1..4)
- BUF_DEPTH, 32: entries in shared downstream buffer
- BURST_LEN, 8: max reads per grant (1..BUF_DEPTH)
- CH_W = clog2(NUM_CH), CNT_W = clog2(BUF_DEPTH+1) (derived localparams)

- m_clk  in  1  clock
- m_rst  in  1  reset, asynchronous, active-high
- fifo_empty  in  NUM_CH  per-channel native FIFO empty
- fifo_rden  out  NUM_CH  per-channel read enable, one-hot or zero
- dout_valid  out  1  FIFO data valid this cycle (write strobe into buffer)
- dout_ch  out  CH_W  channel owning the data on dout_valid
- buf_s_ready  in  1  buffer can accept a write
- m_valid  in  1  buffer output TVALID
- m_ready  in  1  buffer output TREADY
- busy  out  1  state is BURST
- credit_cnt  out  CNT_W  current counter value (debug)
- err  out  1  sticky: overflow (dout_valid & ~buf_s_ready) or counter underflow

## Operation
- States: ARB, BURST. Reset state ARB.
- ARB: search channels starting at last_grant+1 (mod NUM_CH), pick first with fifo_empty=0; register grant, beat=0, go BURST. None non-empty: stay ARB. One arbitration cycle per burst; no rden in ARB.
- BURST: fifo_rden[grant] = ~fifo_empty[grant] & (credit_cnt < BUF_DEPTH); all other bits 0. fifo_rden is combinational from registered state and these inputs.
- Each issued read: beat++. Leave to ARB (last_grant <= grant) when a read is issued with beat == BURST_LEN-1, or when fifo_empty[grant]=1. No credit with non-empty FIFO: stay in BURST, stall.
- Credit counter: +1 on any issued read, -1 on m_valid&m_ready, unchanged on both. Counts buffer occupancy plus in-flight reads; never exceeds BUF_DEPTH.
- Decrement at 0: hold 0, set err.
- Tag pipe: shift register of depth DOUT_PIPE_NUMBER carrying {read_issued, grant}; tail drives dout_valid/dout_ch.
- err set on dout_valid & ~buf_s_ready; cleared only by reset.

## Timing
- Reset (async assert, sync-released usage): state=ARB, last_grant=NUM_CH-1 (first search starts at ch0), beat=0, credit_cnt=0, tag pipe cleared, fifo_rden=0, dout_valid=0, dout_ch=0, busy=0, err=0.
- Reset mid-burst: in-flight tags discarded, credit zeroed; buffer is reset by the same m_rst.
- Latency: channel becomes non-empty at cycle t (sampled at edge t) -> BURST at t+1, first rden in cycle t+1 -> dout_valid in cycle t+1+DOUT_PIPE_NUMBER.
- Steady-state throughput: BURST_LEN reads per BURST_LEN+1 cycles when credit available.
- credit_cnt == BUF_DEPTH: rden deasserts same cycle; resumes the cycle after a drain handshake.
- Simultaneous issue and drain at BUF_DEPTH: not possible (no issue at full); at BUF_DEPTH-1 both -> stays BUF_DEPTH-1.
- Grant wrap: last_grant=NUM_CH-1 searches 0,1,...

## Test plan
- Reset then all four FIFOs non-empty holding 20 words each, m_ready=1: grant order 0,1,2,3,0,... bursts of 8, 8, 4 per channel; dout_ch matches rden channel delayed DOUT_PIPE_NUMBER; err=0.
- Only ch2 non-empty, 3 words: one burst of 3 reads, exit on empty, return to ARB, busy drops; no rden on other bits.
- m_ready=0, ch0 holding 100 words: exactly 32 reads issued, credit_cnt=32, rden held 0; release m_ready for 1 cycle -> exactly one more read next cycle.
- DOUT_PIPE_NUMBER=3: dout_valid pattern equals rden pattern shifted 3 cycles, including stall bubbles.
- Force buf_s_ready=0 on a dout_valid cycle -> err=1 and stays 1; m_valid&m_ready with credit_cnt=0 -> err=1, counter stays 0.
- Assert m_rst mid-burst with credit_cnt=12: all outputs immediately 0, credit_cnt=0; after release, arbitration restarts at ch0.

Source files
------------

// File: rtl/fifo_native_rr_read_scheduler.sv
// Round-robin burst read scheduler for NUM_CH native FIFOs feeding one
// shared downstream buffer, with credit-based overflow protection.
module fifo_native_rr_read_scheduler #(
  parameter  int NUM_CH           = 4,
  parameter  int DOUT_PIPE_NUMBER = 1,
  parameter  int BUF_DEPTH        = 32,
  parameter  int BURST_LEN        = 8,
  localparam int CH_W             = $clog2(NUM_CH),
  localparam int CNT_W            = $clog2(BUF_DEPTH + 1)
) (
  input  logic              m_clk,
  input  logic              m_rst,
  input  logic [NUM_CH-1:0] fifo_empty,
  output logic [NUM_CH-1:0] fifo_rden,
  output logic              dout_valid,
  output logic [CH_W-1:0]   dout_ch,
  input  logic              buf_s_ready,
  input  logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic              err
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int D      = DOUT_PIPE_NUMBER;

  typedef enum logic {ARB, BURST} state_e;

  state_e            state_q;
  logic [CH_W-1:0]   grant_q;
  logic [CH_W-1:0]   last_q;
  logic [BEAT_W-1:0] beat_q;
  logic [CNT_W-1:0]  credit_q;
  logic [CNT_W-1:0]  credit_d;
  logic [D-1:0]      tv_q;
  logic [CH_W-1:0]   tc_q [D];
  logic              err_q;

  logic              found;
  logic [CH_W-1:0]   pick;
  logic [CH_W-1:0]   idx;
  logic              has_credit;
  logic              issue;
  logic              drain;
  logic              underflow;
  logic              last_beat;

  assign has_credit = credit_q < CNT_W'(BUF_DEPTH);
  assign last_beat  = beat_q == BEAT_W'(BURST_LEN - 1);
  assign drain      = m_valid & m_ready;

  always_comb begin
    fifo_rden = '0;
    if (state_q == BURST) begin
      fifo_rden[grant_q] = ~fifo_empty[grant_q] & has_credit;
    end
  end

  assign issue = |fifo_rden;

  // First non-empty channel after the previous grant, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(last_q) + i) % NUM_CH);
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign underflow = drain & ~issue & (credit_q == '0);

  always_comb begin
    credit_d = credit_q;
    if (issue & ~drain) begin
      credit_d = credit_q + CNT_W'(1);
    end else if (drain & ~issue & ~underflow) begin
      credit_d = credit_q - CNT_W'(1);
    end
  end

  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      state_q  <= ARB;
      grant_q  <= '0;
      last_q   <= CH_W'(NUM_CH - 1);
      beat_q   <= '0;
      credit_q <= '0;
      tv_q     <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < D; i++) begin
        tc_q[i] <= '0;
      end
    end else begin
      credit_q <= credit_d;
      if ((dout_valid & ~buf_s_ready) | underflow) begin
        err_q <= 1'b1;
      end
      tv_q[0] <= issue;
      tc_q[0] <= grant_q;
      for (int i = 1; i < D; i++) begin
        tv_q[i] <= tv_q[i-1];
        tc_q[i] <= tc_q[i-1];
      end
      unique case (state_q)
        ARB: begin
          if (found) begin
            grant_q <= pick;
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            beat_q <= beat_q + BEAT_W'(1);
          end
          if ((issue & last_beat) | fifo_empty[grant_q]) begin
            state_q <= ARB;
            last_q  <= grant_q;
          end
        end
      endcase
    end
  end

  assign dout_valid = tv_q[D-1];
  assign dout_ch    = tc_q[D-1];
  assign busy       = state_q == BURST;
  assign credit_cnt = credit_q;
  assign err        = err_q;

endmodule
